// File: rtl/apb_uart_pkg.sv
// Shared definitions for the multi-channel UART register interface:
// register offsets, per-register types and the bus FSM state encoding.
package apb_uart_pkg;

   // Each channel window decodes a 6-bit byte offset
   localparam int REG_OFF_W = 6;

   localparam logic [REG_OFF_W-1:0] OFF_CTRL          = 6'h00;
   localparam logic [REG_OFF_W-1:0] OFF_CLK_DIV       = 6'h04;
   localparam logic [REG_OFF_W-1:0] OFF_CFG           = 6'h08;
   localparam logic [REG_OFF_W-1:0] OFF_TX_FIFO_COUNT = 6'h0C;
   localparam logic [REG_OFF_W-1:0] OFF_RX_FIFO_COUNT = 6'h10;
   localparam logic [REG_OFF_W-1:0] OFF_TX_DATA       = 6'h14;
   localparam logic [REG_OFF_W-1:0] OFF_RX_DATA       = 6'h18;
   localparam logic [REG_OFF_W-1:0] OFF_INTR_CTRL     = 6'h1C;
   localparam logic [REG_OFF_W-1:0] OFF_INTR_STAT     = 6'h20;

   typedef enum logic [REG_OFF_W-1:0] {
      REG_CTRL          = OFF_CTRL,
      REG_CLK_DIV       = OFF_CLK_DIV,
      REG_CFG           = OFF_CFG,
      REG_TX_FIFO_COUNT = OFF_TX_FIFO_COUNT,
      REG_RX_FIFO_COUNT = OFF_RX_FIFO_COUNT,
      REG_TX_DATA       = OFF_TX_DATA,
      REG_RX_DATA       = OFF_RX_DATA,
      REG_INTR_CTRL     = OFF_INTR_CTRL,
      REG_INTR_STAT     = OFF_INTR_STAT
   } uart_reg_off_e;

   // Default baud divider after reset
   localparam logic [31:0] UART_CLK_DIV_RST = 32'h0000_2580;

   typedef logic [31:0] uart_ctrl_t;
   typedef logic [31:0] uart_clk_div_t;
   typedef logic [31:0] uart_cfg_t;
   typedef logic [31:0] uart_intr_ctrl_t;
   typedef logic [7:0]  uart_intr_stat_t;

   typedef struct packed {
      uart_ctrl_t      ctrl;
      uart_clk_div_t   clk_div;
      uart_cfg_t       cfg;
      uart_intr_ctrl_t intr_ctrl;
      uart_intr_stat_t intr_stat;
   } uart_ch_regs_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } uart_bus_state_e;

endpackage

// File: rtl/uart_ch_regbank.sv
// One UART channel's register storage: byte-strobed RW registers,
// write-1-to-clear interrupt status and the channel's irq line.
module uart_ch_regbank
   import apb_uart_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 32,
   parameter int                    INTR_W      = 8,
   parameter logic [DATA_WIDTH-1:0] CLK_DIV_RST = DATA_WIDTH'(UART_CLK_DIV_RST)
) (
   input  logic                    clk_i,
   input  logic                    arst_ni,
   input  logic                    wr_en,
   input  logic [REG_OFF_W-1:0]    wr_off,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_strb,
   input  logic [INTR_W-1:0]       intr_evt,
   output logic [DATA_WIDTH-1:0]   ctrl_reg,
   output logic [DATA_WIDTH-1:0]   clk_div_reg,
   output logic [DATA_WIDTH-1:0]   cfg_reg,
   output logic [DATA_WIDTH-1:0]   intr_ctrl_reg,
   output logic [INTR_W-1:0]       intr_stat,
   output logic                    irq
);

   localparam int STRB_W = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] byte_mask;
   logic [INTR_W-1:0]     w1c_mask;

   // Expand byte strobes into a bit mask shared by every register merge
   always_comb begin
      byte_mask = '0;
      for (int b = 0; b < STRB_W; b++) begin
         byte_mask[b*8 +: 8] = {8{wr_strb[b]}};
      end
   end

   // Strobed clear mask, only live for a write that targets the status register
   always_comb begin
      w1c_mask = '0;
      if (wr_en && (wr_off == REG_INTR_STAT)) begin
         w1c_mask = wr_data[INTR_W-1:0] & byte_mask[INTR_W-1:0];
      end
   end

   // RW registers keep unstrobed bytes and take new data in strobed bytes
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         ctrl_reg      <= '0;
         clk_div_reg   <= CLK_DIV_RST;
         cfg_reg       <= '0;
         intr_ctrl_reg <= '0;
      end else if (wr_en) begin
         case (wr_off)
            REG_CTRL:      ctrl_reg      <= (ctrl_reg      & ~byte_mask) | (wr_data & byte_mask);
            REG_CLK_DIV:   clk_div_reg   <= (clk_div_reg   & ~byte_mask) | (wr_data & byte_mask);
            REG_CFG:       cfg_reg       <= (cfg_reg       & ~byte_mask) | (wr_data & byte_mask);
            REG_INTR_CTRL: intr_ctrl_reg <= (intr_ctrl_reg & ~byte_mask) | (wr_data & byte_mask);
            default: ;
         endcase
      end
   end

   // Status clears on W1C but a coincident event always re-sets the bit
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         intr_stat <= '0;
      end else begin
         intr_stat <= (intr_stat & ~w1c_mask) | intr_evt;
      end
   end

   assign irq = |(intr_stat & intr_ctrl_reg[INTR_W-1:0]);

endmodule

// File: rtl/uart_multi_regif.sv
// Multi-channel UART register interface: decodes the memory request
// stream into per-channel banks, checks for errors and returns a
// registered one-cycle acknowledge.
module uart_multi_regif
   import apb_uart_pkg::*;
#(
   parameter int                    NUM_CH       = 2,
   parameter int                    ADDR_WIDTH   = 9,
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    CH_ADDR_BITS = 6,
   parameter int                    INTR_W       = 8,
   parameter logic [DATA_WIDTH-1:0] CLK_DIV_RST  = DATA_WIDTH'(UART_CLK_DIV_RST)
) (
   input  logic                                clk_i,
   input  logic                                arst_ni,
   input  logic                                mreq_i,
   input  logic [ADDR_WIDTH-1:0]               maddr_i,
   input  logic                                mwe_i,
   input  logic [DATA_WIDTH-1:0]               mwdata_i,
   input  logic [DATA_WIDTH/8-1:0]             mstrb_i,
   output logic                                mack_o,
   output logic [DATA_WIDTH-1:0]               mrdata_o,
   output logic                                mresp_o,
   output logic [NUM_CH-1:0][DATA_WIDTH-1:0]   ctrl_reg_o,
   output logic [NUM_CH-1:0][DATA_WIDTH-1:0]   clk_div_reg_o,
   output logic [NUM_CH-1:0][DATA_WIDTH-1:0]   cfg_reg_o,
   output logic [NUM_CH-1:0][DATA_WIDTH-1:0]   intr_ctrl_reg_o,
   input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]   tx_fifo_count_i,
   input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]   rx_fifo_count_i,
   output logic [DATA_WIDTH-1:0]               tx_data_o,
   output logic [NUM_CH-1:0]                   tx_data_valid_o,
   input  logic [NUM_CH-1:0]                   tx_data_ready_i,
   input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]   rx_data_i,
   input  logic [NUM_CH-1:0]                   rx_data_valid_i,
   output logic [NUM_CH-1:0]                   rx_data_ready_o,
   input  logic [NUM_CH-1:0][INTR_W-1:0]       intr_evt_i,
   output logic [NUM_CH-1:0]                   irq_o
);

   localparam int CH_IDX_W = ADDR_WIDTH - CH_ADDR_BITS;

   uart_bus_state_e state_q, state_d;

   logic [CH_IDX_W-1:0]      ch_idx;
   logic [CH_ADDR_BITS-1:0]  off_full;
   logic [REG_OFF_W-1:0]     off;
   logic                     off_in_range;
   logic                     ch_valid;
   logic [NUM_CH-1:0]        ch_hit;

   logic [DATA_WIDTH-1:0]    sel_ctrl, sel_clk_div, sel_cfg, sel_intr_ctrl;
   logic [DATA_WIDTH-1:0]    sel_tx_cnt, sel_rx_cnt, sel_rx_data;
   logic [INTR_W-1:0]        sel_stat;
   logic                     sel_tx_ready, sel_rx_valid;

   logic                     acc_err;
   logic [DATA_WIDTH-1:0]    rd_data;
   logic                     accept;
   logic                     good_write;
   logic                     good_read;
   logic [NUM_CH-1:0]        bank_wr;

   logic [NUM_CH-1:0][INTR_W-1:0] stat_q;
   logic [DATA_WIDTH-1:0]    mrdata_q;
   logic                     mresp_q;

   assign ch_idx       = maddr_i[ADDR_WIDTH-1:CH_ADDR_BITS];
   assign off_full     = maddr_i[CH_ADDR_BITS-1:0];
   assign off          = off_full[REG_OFF_W-1:0];
   assign off_in_range = (int'(off_full) < (1 << REG_OFF_W));
   assign ch_valid     = (int'(ch_idx) < NUM_CH);

   // Steer the addressed channel's registers and FIFO status onto shared select buses
   always_comb begin
      ch_hit        = '0;
      sel_ctrl      = '0;
      sel_clk_div   = '0;
      sel_cfg       = '0;
      sel_intr_ctrl = '0;
      sel_tx_cnt    = '0;
      sel_rx_cnt    = '0;
      sel_rx_data   = '0;
      sel_stat      = '0;
      sel_tx_ready  = 1'b0;
      sel_rx_valid  = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (int'(ch_idx) == c) begin
            ch_hit[c]     = 1'b1;
            sel_ctrl      = ctrl_reg_o[c];
            sel_clk_div   = clk_div_reg_o[c];
            sel_cfg       = cfg_reg_o[c];
            sel_intr_ctrl = intr_ctrl_reg_o[c];
            sel_tx_cnt    = tx_fifo_count_i[c];
            sel_rx_cnt    = rx_fifo_count_i[c];
            sel_rx_data   = rx_data_i[c];
            sel_stat      = stat_q[c];
            sel_tx_ready  = tx_data_ready_i[c];
            sel_rx_valid  = rx_data_valid_i[c];
         end
      end
   end

   // Classify the request as legal or erroneous and build its read data
   always_comb begin
      acc_err = 1'b0;
      rd_data = '0;
      case (off)
         REG_CTRL:      rd_data = sel_ctrl;
         REG_CLK_DIV: begin
            rd_data = sel_clk_div;
            if (mwe_i && ((sel_tx_cnt != '0) || (sel_rx_cnt != '0))) acc_err = 1'b1;
         end
         REG_CFG: begin
            rd_data = sel_cfg;
            if (mwe_i && ((sel_tx_cnt != '0) || (sel_rx_cnt != '0))) acc_err = 1'b1;
         end
         REG_TX_FIFO_COUNT: begin
            rd_data = sel_tx_cnt;
            if (mwe_i) acc_err = 1'b1;
         end
         REG_RX_FIFO_COUNT: begin
            rd_data = sel_rx_cnt;
            if (mwe_i) acc_err = 1'b1;
         end
         REG_TX_DATA: begin
            if (!mwe_i || !sel_tx_ready || !mstrb_i[0]) acc_err = 1'b1;
         end
         REG_RX_DATA: begin
            rd_data = sel_rx_data;
            if (mwe_i || !sel_rx_valid) acc_err = 1'b1;
         end
         REG_INTR_CTRL: rd_data = sel_intr_ctrl;
         REG_INTR_STAT: rd_data = DATA_WIDTH'(sel_stat);
         default:       acc_err = 1'b1;
      endcase
      if (!ch_valid || !off_in_range) acc_err = 1'b1;
   end

   assign accept     = (state_q == ST_IDLE) && mreq_i;
   assign good_write = accept && mwe_i && !acc_err;
   assign good_read  = accept && !mwe_i && !acc_err;
   assign bank_wr    = good_write ? ch_hit : '0;

   assign tx_data_o       = mwdata_i;
   assign tx_data_valid_o = (good_write && (off == REG_TX_DATA)) ? ch_hit : '0;
   assign rx_data_ready_o = (good_read && (off == REG_RX_DATA)) ? ch_hit : '0;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_bank
      uart_ch_regbank #(
         .DATA_WIDTH  (DATA_WIDTH),
         .INTR_W      (INTR_W),
         .CLK_DIV_RST (CLK_DIV_RST)
      ) u_bank (
         .clk_i         (clk_i),
         .arst_ni       (arst_ni),
         .wr_en         (bank_wr[c]),
         .wr_off        (off),
         .wr_data       (mwdata_i),
         .wr_strb       (mstrb_i),
         .intr_evt      (intr_evt_i[c]),
         .ctrl_reg      (ctrl_reg_o[c]),
         .clk_div_reg   (clk_div_reg_o[c]),
         .cfg_reg       (cfg_reg_o[c]),
         .intr_ctrl_reg (intr_ctrl_reg_o[c]),
         .intr_stat     (stat_q[c]),
         .irq           (irq_o[c])
      );
   end

   // Bus FSM state register
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Accept in IDLE, acknowledge for one cycle in RESP; requests in RESP are ignored
   always_comb begin
      state_d = state_q;
      mack_o  = 1'b0;
      case (state_q)
         ST_IDLE: if (mreq_i) state_d = ST_RESP;
         ST_RESP: begin
            mack_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Capture the response at acceptance so it is stable throughout the ack cycle
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         mrdata_q <= '0;
         mresp_q  <= 1'b0;
      end else if (accept) begin
         mresp_q  <= acc_err;
         mrdata_q <= (acc_err || mwe_i) ? '0 : rd_data;
      end
   end

   assign mrdata_o = mrdata_q;
   assign mresp_o  = mresp_q;

endmodule

// File: tb/tb_uart_multi_regif.sv
// Directed self-checking bench for uart_multi_regif with two channels.
module tb_uart_multi_regif;

   logic              clk_i = 1'b0;
   logic              arst_ni;
   logic              mreq_i;
   logic [8:0]        maddr_i;
   logic              mwe_i;
   logic [31:0]       mwdata_i;
   logic [3:0]        mstrb_i;
   logic              mack_o;
   logic [31:0]       mrdata_o;
   logic              mresp_o;
   logic [1:0][31:0]  ctrl_reg_o;
   logic [1:0][31:0]  clk_div_reg_o;
   logic [1:0][31:0]  cfg_reg_o;
   logic [1:0][31:0]  intr_ctrl_reg_o;
   logic [1:0][31:0]  tx_fifo_count_i;
   logic [1:0][31:0]  rx_fifo_count_i;
   logic [31:0]       tx_data_o;
   logic [1:0]        tx_data_valid_o;
   logic [1:0]        tx_data_ready_i;
   logic [1:0][31:0]  rx_data_i;
   logic [1:0]        rx_data_valid_i;
   logic [1:0]        rx_data_ready_o;
   logic [1:0][7:0]   intr_evt_i;
   logic [1:0]        irq_o;

   int checks   = 0;
   int failures = 0;

   logic [31:0] rd;
   logic        rsp;
   logic        ack_ok;
   logic        pulse_off;
   logic [1:0]  txv;
   logic [1:0]  rxr;
   logic [31:0] txd;

   uart_multi_regif dut (
      .clk_i           (clk_i),
      .arst_ni         (arst_ni),
      .mreq_i          (mreq_i),
      .maddr_i         (maddr_i),
      .mwe_i           (mwe_i),
      .mwdata_i        (mwdata_i),
      .mstrb_i         (mstrb_i),
      .mack_o          (mack_o),
      .mrdata_o        (mrdata_o),
      .mresp_o         (mresp_o),
      .ctrl_reg_o      (ctrl_reg_o),
      .clk_div_reg_o   (clk_div_reg_o),
      .cfg_reg_o       (cfg_reg_o),
      .intr_ctrl_reg_o (intr_ctrl_reg_o),
      .tx_fifo_count_i (tx_fifo_count_i),
      .rx_fifo_count_i (rx_fifo_count_i),
      .tx_data_o       (tx_data_o),
      .tx_data_valid_o (tx_data_valid_o),
      .tx_data_ready_i (tx_data_ready_i),
      .rx_data_i       (rx_data_i),
      .rx_data_valid_i (rx_data_valid_i),
      .rx_data_ready_o (rx_data_ready_o),
      .intr_evt_i      (intr_evt_i),
      .irq_o           (irq_o)
   );

   // Free-running 100 MHz clock
   always #5 clk_i = ~clk_i;

   // One complete access; entered and left 1 ns after a rising edge
   task automatic bus_xfer(input logic we, input logic [8:0] addr,
                           input logic [31:0] wd, input logic [3:0] st);
      mreq_i   = 1'b1;
      mwe_i    = we;
      maddr_i  = addr;
      mwdata_i = wd;
      mstrb_i  = st;
      #1;
      txv = tx_data_valid_o;
      rxr = rx_data_ready_o;
      txd = tx_data_o;
      @(posedge clk_i); #1;
      ack_ok    = mack_o;
      rd        = mrdata_o;
      rsp       = mresp_o;
      pulse_off = (tx_data_valid_o == 2'b00) && (rx_data_ready_o == 2'b00);
      mreq_i    = 1'b0;
      @(posedge clk_i); #1;
      ack_ok = ack_ok && !mack_o;
   endtask

   task automatic test_reset();
      arst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      checks++; if (mack_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_mack: got %b expected 0", mack_o); end
      checks++; if (mresp_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_mresp: got %b expected 0", mresp_o); end
      checks++; if (mrdata_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_mrdata: got %h expected 0", mrdata_o); end
      checks++; if (irq_o !== 2'b00) begin failures++; $display("[TB] FAIL reset_irq: got %b expected 00", irq_o); end
      checks++; if (ctrl_reg_o[0] !== 32'h0) begin failures++; $display("[TB] FAIL reset_ctrl: got %h expected 0", ctrl_reg_o[0]); end
      checks++; if (clk_div_reg_o[1] !== 32'h2580) begin failures++; $display("[TB] FAIL reset_clk_div: got %h expected 2580", clk_div_reg_o[1]); end
      arst_ni = 1'b1;
      @(posedge clk_i); #1;
   endtask

   task automatic test_clkdiv_read();
      bus_xfer(1'b0, 9'h044, 32'h0, 4'h0);
      checks++; if (ack_ok !== 1'b1) begin failures++; $display("[TB] FAIL clkdiv_ack: got %b expected 1", ack_ok); end
      checks++; if (rd !== 32'h2580) begin failures++; $display("[TB] FAIL clkdiv_rdata: got %h expected 2580", rd); end
      checks++; if (rsp !== 1'b0) begin failures++; $display("[TB] FAIL clkdiv_resp: got %b expected 0", rsp); end
   endtask

   task automatic test_strobe_write();
      bus_xfer(1'b1, 9'h000, 32'hAABBCCDD, 4'b0101);
      checks++; if (ctrl_reg_o[0] !== 32'h00BB00DD) begin failures++; $display("[TB] FAIL strobe_ctrl: got %h expected 00BB00DD", ctrl_reg_o[0]); end
      bus_xfer(1'b1, 9'h000, 32'h11223344, 4'b0000);
      checks++; if (rsp !== 1'b0) begin failures++; $display("[TB] FAIL strobe_zero_resp: got %b expected 0", rsp); end
      bus_xfer(1'b0, 9'h000, 32'h0, 4'h0);
      checks++; if (rd !== 32'h00BB00DD) begin failures++; $display("[TB] FAIL strobe_readback: got %h expected 00BB00DD", rd); end
   endtask

   task automatic test_cfg_lock();
      tx_fifo_count_i[0] = 32'd3;
      bus_xfer(1'b1, 9'h008, 32'h5, 4'hF);
      checks++; if (rsp !== 1'b1) begin failures++; $display("[TB] FAIL cfg_locked_resp: got %b expected 1", rsp); end
      checks++; if (cfg_reg_o[0] !== 32'h0) begin failures++; $display("[TB] FAIL cfg_locked_value: got %h expected 0", cfg_reg_o[0]); end
      tx_fifo_count_i[0] = 32'd0;
      bus_xfer(1'b1, 9'h008, 32'h5, 4'hF);
      checks++; if (rsp !== 1'b0) begin failures++; $display("[TB] FAIL cfg_open_resp: got %b expected 0", rsp); end
      checks++; if (cfg_reg_o[0] !== 32'h5) begin failures++; $display("[TB] FAIL cfg_open_value: got %h expected 5", cfg_reg_o[0]); end
   endtask

   task automatic test_tx_data();
      tx_data_ready_i = 2'b11;
      bus_xfer(1'b1, 9'h054, 32'h41, 4'hF);
      checks++; if (txv !== 2'b10) begin failures++; $display("[TB] FAIL tx_valid: got %b expected 10", txv); end
      checks++; if (txd !== 32'h41) begin failures++; $display("[TB] FAIL tx_data: got %h expected 41", txd); end
      checks++; if (pulse_off !== 1'b1) begin failures++; $display("[TB] FAIL tx_pulse_width: got %b expected 1", pulse_off); end
      checks++; if (rsp !== 1'b0) begin failures++; $display("[TB] FAIL tx_resp: got %b expected 0", rsp); end
      tx_data_ready_i = 2'b01;
      bus_xfer(1'b1, 9'h054, 32'h41, 4'hF);
      checks++; if (rsp !== 1'b1) begin failures++; $display("[TB] FAIL tx_full_resp: got %b expected 1", rsp); end
      checks++; if (txv !== 2'b00) begin failures++; $display("[TB] FAIL tx_full_valid: got %b expected 00", txv); end
      bus_xfer(1'b0, 9'h014, 32'h0, 4'h0);
      checks++; if (rsp !== 1'b1) begin failures++; $display("[TB] FAIL tx_read_resp: got %b expected 1", rsp); end
      tx_data_ready_i = 2'b11;
   endtask

   task automatic test_rx_data();
      rx_data_valid_i = 2'b01;
      rx_data_i[0]    = 32'h5A;
      bus_xfer(1'b0, 9'h018, 32'h0, 4'h0);
      checks++; if (rd !== 32'h5A) begin failures++; $display("[TB] FAIL rx_rdata: got %h expected 5A", rd); end
      checks++; if (rxr !== 2'b01) begin failures++; $display("[TB] FAIL rx_ready: got %b expected 01", rxr); end
      checks++; if (pulse_off !== 1'b1) begin failures++; $display("[TB] FAIL rx_pulse_width: got %b expected 1", pulse_off); end
      rx_data_valid_i = 2'b00;
      bus_xfer(1'b0, 9'h018, 32'h0, 4'h0);
      checks++; if (rsp !== 1'b1) begin failures++; $display("[TB] FAIL rx_empty_resp: got %b expected 1", rsp); end
      checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL rx_empty_rdata: got %h expected 0", rd); end
      checks++; if (rxr !== 2'b00) begin failures++; $display("[TB] FAIL rx_empty_ready: got %b expected 00", rxr); end
   endtask

   task automatic test_interrupts();
      bus_xfer(1'b1, 9'h01C, 32'h3, 4'hF);
      intr_evt_i[0] = 8'h02;
      @(posedge clk_i); #1;
      intr_evt_i[0] = 8'h00;
      checks++; if (irq_o !== 2'b01) begin failures++; $display("[TB] FAIL irq_set: got %b expected 01", irq_o); end
      bus_xfer(1'b0, 9'h020, 32'h0, 4'h0);
      checks++; if (rd !== 32'h2) begin failures++; $display("[TB] FAIL stat_read: got %h expected 2", rd); end
      // W1C and a fresh event on the same bit land on the same edge
      mreq_i        = 1'b1;
      mwe_i         = 1'b1;
      maddr_i       = 9'h020;
      mwdata_i      = 32'h2;
      mstrb_i       = 4'hF;
      intr_evt_i[0] = 8'h02;
      @(posedge clk_i); #1;
      mreq_i        = 1'b0;
      intr_evt_i[0] = 8'h00;
      checks++; if (irq_o[0] !== 1'b1) begin failures++; $display("[TB] FAIL irq_set_wins: got %b expected 1", irq_o[0]); end
      @(posedge clk_i); #1;
      bus_xfer(1'b1, 9'h020, 32'h2, 4'hF);
      checks++; if (irq_o[0] !== 1'b0) begin failures++; $display("[TB] FAIL irq_cleared: got %b expected 0", irq_o[0]); end
      bus_xfer(1'b0, 9'h020, 32'h0, 4'h0);
      checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL stat_cleared: got %h expected 0", rd); end
   endtask

   task automatic test_decode_errors();
      bus_xfer(1'b0, 9'h1C0, 32'h0, 4'h0);
      checks++; if (rsp !== 1'b1) begin failures++; $display("[TB] FAIL bad_ch_resp: got %b expected 1", rsp); end
      checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL bad_ch_rdata: got %h expected 0", rd); end
      bus_xfer(1'b0, 9'h024, 32'h0, 4'h0);
      checks++; if (rsp !== 1'b1) begin failures++; $display("[TB] FAIL unmapped_resp: got %b expected 1", rsp); end
      bus_xfer(1'b1, 9'h00C, 32'h7, 4'hF);
      checks++; if (rsp !== 1'b1) begin failures++; $display("[TB] FAIL ro_write_resp: got %b expected 1", rsp); end
      bus_xfer(1'b1, 9'h040, 32'h12345678, 4'hF);
      checks++; if (ctrl_reg_o !== {32'h12345678, 32'h00BB00DD}) begin failures++; $display("[TB] FAIL ch1_ctrl_isolation: got %h expected 1234567800BB00DD", ctrl_reg_o); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] acks;
      mreq_i  = 1'b1;
      mwe_i   = 1'b0;
      maddr_i = 9'h004;
      mstrb_i = 4'h0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk_i); #1;
         acks[i] = mack_o;
      end
      mreq_i = 1'b0;
      @(posedge clk_i); #1;
      checks++; if (acks !== 4'b0101) begin failures++; $display("[TB] FAIL b2b_ack_pattern: got %b expected 0101", acks); end
   endtask

   task automatic test_reset_in_resp();
      mreq_i  = 1'b1;
      mwe_i   = 1'b0;
      maddr_i = 9'h004;
      @(posedge clk_i); #1;
      mreq_i = 1'b0;
      checks++; if (mack_o !== 1'b1) begin failures++; $display("[TB] FAIL rir_ack_before: got %b expected 1", mack_o); end
      #2;
      arst_ni = 1'b0;
      #1;
      checks++; if (mack_o !== 1'b0) begin failures++; $display("[TB] FAIL rir_ack_drop: got %b expected 0", mack_o); end
      @(posedge clk_i); #1;
      arst_ni = 1'b1;
      @(posedge clk_i); #1;
      checks++; if (mack_o !== 1'b0) begin failures++; $display("[TB] FAIL rir_no_resp: got %b expected 0", mack_o); end
      checks++; if (ctrl_reg_o[0] !== 32'h0) begin failures++; $display("[TB] FAIL rir_ctrl_reset: got %h expected 0", ctrl_reg_o[0]); end
   endtask

   // Run every scenario in order, then report
   initial begin
      mreq_i          = 1'b0;
      maddr_i         = '0;
      mwe_i           = 1'b0;
      mwdata_i        = '0;
      mstrb_i         = '0;
      tx_fifo_count_i = '0;
      rx_fifo_count_i = '0;
      tx_data_ready_i = 2'b11;
      rx_data_i       = '0;
      rx_data_valid_i = 2'b00;
      intr_evt_i      = '0;
      test_reset();
      test_clkdiv_read();
      test_strobe_write();
      test_cfg_lock();
      test_tx_data();
      test_rx_data();
      test_interrupts();
      test_decode_errors();
      test_back_to_back();
      test_reset_in_resp();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_multi_regif.md
Name: uart_multi_regif

Overview:
Multi-channel, registered-response successor to the single-channel UART register interface.
- Decodes one memory-interface request stream into NUM_CH identical per-channel register banks.
- Honours byte strobes and adds a write-1-to-clear interrupt status register with per-channel irq outputs.
- Sits between the APB-to-memory bridge and NUM_CH UART TX/RX cores with their FIFOs.

Parameters:
NUM_CH, 2, number of UART channels (1..8)
ADDR_WIDTH, 9, memory address width; bits [ADDR_WIDTH-1:CH_ADDR_BITS] select the channel
DATA_WIDTH, 32, data width; multiple of 8
CH_ADDR_BITS, 6, per-channel window of 64 bytes
INTR_W, 8, interrupt event bits per channel
CLK_DIV_RST, 'h2580, reset value of CLK_DIV

Ports:
clk_i  in  1  global clock
arst_ni  in  1  asynchronous active-low reset
mreq_i  in  1  request; held high by master until mack_o
maddr_i  in  ADDR_WIDTH  byte address
mwe_i  in  1  write enable
mwdata_i  in  DATA_WIDTH  write data
mstrb_i  in  DATA_WIDTH/8  byte strobes
mack_o  out  1  one-cycle acknowledge
mrdata_o  out  DATA_WIDTH  read data, valid with mack_o
mresp_o  out  1  error flag, valid with mack_o
ctrl_reg_o  out  NUM_CH x DATA_WIDTH  CTRL per channel
clk_div_reg_o  out  NUM_CH x DATA_WIDTH  CLK_DIV per channel
cfg_reg_o  out  NUM_CH x DATA_WIDTH  CFG per channel
intr_ctrl_reg_o  out  NUM_CH x DATA_WIDTH  interrupt enables; low INTR_W bits used
tx_fifo_count_i  in  NUM_CH x DATA_WIDTH  TX FIFO occupancy
rx_fifo_count_i  in  NUM_CH x DATA_WIDTH  RX FIFO occupancy
tx_data_o  out  DATA_WIDTH  TX push data, shared by all channels
tx_data_valid_o  out  NUM_CH  per-channel TX push strobe
tx_data_ready_i  in  NUM_CH  TX FIFO not full
rx_data_i  in  NUM_CH x DATA_WIDTH  RX FIFO head
rx_data_valid_i  in  NUM_CH  RX FIFO not empty
rx_data_ready_o  out  NUM_CH  RX pop strobe
intr_evt_i  in  NUM_CH x INTR_W  single-cycle interrupt event pulses
irq_o  out  NUM_CH  |(INTR_STAT & INTR_CTRL[INTR_W-1:0])

Behaviour:
- Offsets: CTRL 0x00 RW; CLK_DIV 0x04 RW; CFG 0x08 RW; TX_FIFO_COUNT 0x0C RO; RX_FIFO_COUNT 0x10 RO; TX_DATA 0x14 WO; RX_DATA 0x18 RO-pop; INTR_CTRL 0x1C RW; INTR_STAT 0x20 RW1C.
- FSM IDLE/RESP:
  - IDLE with mreq_i: the request is accepted and all side effects happen on that edge; next state RESP.
  - RESP: mack_o=1 for exactly one cycle with mrdata_o and mresp_o, then IDLE.
  - Throughput is one access per 2 cycles. mreq_i seen in RESP is ignored.
- Errors set mresp_o=1 with mrdata_o=0 and no side effects. Error cases:
  - channel index >= NUM_CH, or unmapped offset;
  - write to an RO offset, or read of TX_DATA;
  - CLK_DIV or CFG write unless that channel's tx and rx counts are both 0;
  - TX_DATA write with tx_data_ready_i=0 or mstrb_i[0]=0;
  - RX_DATA read with rx_data_valid_i=0.
- RW writes update only the bytes whose mstrb_i bit is set. mstrb_i=0 is a legal write with no update.
- TX_DATA write on acceptance: tx_data_valid_o[ch]=1 for that one cycle; tx_data_o=mwdata_i (low byte is the character).
- RX_DATA read: mrdata_o is captured from rx_data_i[ch] at acceptance; rx_data_ready_o[ch]=1 for that one cycle only.
- INTR_STAT update each cycle: stat <= (stat & ~w1c) | intr_evt_i. If an event and a W1C hit the same bit in the same cycle, set wins. Bits above INTR_W read as 0.
- irq_o is combinational from the registered stat and enables.
- Reset values:
  - mack_o/mresp_o=0, mrdata_o=0, FSM=IDLE;
  - CTRL/CFG/INTR_CTRL/INTR_STAT=0, CLK_DIV=CLK_DIV_RST;
  - strobes 0, irq_o=0.
- Reset asserted in RESP: mack_o drops asynchronously and no response is issued. The in-flight access's register update persists.

Decomposition:
- apb_uart_pkg holds: register offset localparams; uart_reg_off_e; per-register typedefs; uart_ch_regs_t struct; CLK_DIV reset constant.
- One sub-module, uart_ch_regbank, holds per-channel register storage, strobe merge, W1C logic and irq. It is instantiated NUM_CH times.
- The top level holds the decode, error logic and FSM.

Test Plan:
- Reset, then read ch1 CLK_DIV (0x44) -> mack_o 1 cycle after accept, mrdata_o=0x2580, mresp_o=0.
- Write ch0 CTRL 0xAABBCCDD with mstrb_i=4'b0101, after prior value 0 -> reads back 0x00BB00DD.
- ch0 tx_count=3, write CFG=0x5 -> mresp_o=1, CFG stays 0; after counts go to 0 the same write succeeds.
- Write ch1 TX_DATA 0x41 with ready=1 -> tx_data_valid_o=2'b10 exactly one cycle, tx_data_o=0x41. Repeat with ready=0 -> mresp_o=1, no pulse.
- rx_data_valid_i[0]=1, rx_data_i=0x5A, read ch0 RX_DATA -> mrdata_o=0x5A, single ready pulse. Read with valid=0 -> mresp_o=1, mrdata_o=0.
- Set INTR_CTRL=0x3, pulse evt bit1 -> irq_o[0]=1.
  - W1C 0x2 in the same cycle as a new bit1 event -> bit stays set.
  - Later W1C 0x2 -> irq_o[0]=0.
- Address with channel index 7 (NUM_CH=2) -> mresp_o=1.
